bin2rns_sched: RTL and testbench

Time-shared binary-to-RNS conversion controller for the (32, 31, 21, 5) moduli set, 16-bit dynamic range. Arbitrates two requesters onto one radix-16 modular-reduction datapath. Sequences that datapath over the three odd moduli and returns all four residues with the requester tag. Sits between the operand sources and the RNS arithmetic channels, in place of four parallel reducers where area matters more than throughput.

---
 rtl/bin2rns_sched.sv | 139 +++++++++++++
 tb/tb_bin2rns_sched.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bin2rns_sched.sv
// Time-shared binary-to-RNS converter for moduli (32, 31, 21, 5): one radix-16 reducer walks the odd moduli.
// Define BIN2RNS_SCHED_RR_EN for round-robin arbitration; left undefined, requester 0 has fixed priority.
module bin2rns_sched #(
  parameter int DYN_SIZE = 16,
  parameter int MAX_MOD  = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid_0,
  input  logic                in_valid_1,
  input  logic [DYN_SIZE-1:0] in_data_0,
  input  logic [DYN_SIZE-1:0] in_data_1,
  output logic                in_ready_0,
  output logic                in_ready_1,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_id,
  output logic [MAX_MOD-1:0]  out_mod_1,
  output logic [MAX_MOD-1:0]  out_mod_2,
  output logic [MAX_MOD-1:0]  out_mod_3,
  output logic [MAX_MOD-1:0]  out_mod_4,
  output logic                busy
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t              state;
  logic [DYN_SIZE-1:0] n;
  logic [MAX_MOD-1:0]  r;
  logic [1:0]          mod_sel;
  logic [1:0]          digit;
  logic                gnt_0;
  logic                gnt_1;
  logic [3:0]          nib;
  logic [8:0]          acc;
  logic [MAX_MOD-1:0]  red;

`ifdef BIN2RNS_SCHED_RR_EN
  logic prio;

  assign gnt_0 = in_valid_0 && (!in_valid_1 || !prio);
  assign gnt_1 = in_valid_1 && (!in_valid_0 || prio);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prio <= 1'b0;
    end else if (in_ready_0) begin
      prio <= 1'b1;
    end else if (in_ready_1) begin
      prio <= 1'b0;
    end
  end
`else
  assign gnt_0 = in_valid_0;
  assign gnt_1 = in_valid_1 && !in_valid_0;
`endif

  // Grants are masked while reset is asserted so the ready outputs read 0 during reset.
  assign in_ready_0 = reset && (state == IDLE) && gnt_0;
  assign in_ready_1 = reset && (state == IDLE) && gnt_1;
  assign out_valid  = (state == DONE);
  assign busy       = (state != IDLE);

  always_comb begin
    nib = n[3:0];
    case (digit)
      2'd3:    nib = n[15:12];
      2'd2:    nib = n[11:8];
      2'd1:    nib = n[7:4];
      default: nib = n[3:0];
    endcase
  end

  // r < m <= 31 keeps 16*r + nibble within 9 bits.
  assign acc = {r, 4'b0000} + {5'b00000, nib};

  always_comb begin
    red = '0;
    case (mod_sel)
      2'd0:    red = MAX_MOD'(acc % 9'd31);
      2'd1:    red = MAX_MOD'(acc % 9'd21);
      default: red = MAX_MOD'(acc % 9'd5);
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      n         <= '0;
      r         <= '0;
      mod_sel   <= '0;
      digit     <= '0;
      out_id    <= 1'b0;
      out_mod_1 <= '0;
      out_mod_2 <= '0;
      out_mod_3 <= '0;
      out_mod_4 <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_ready_0 || in_ready_1) begin
            n         <= in_ready_1 ? in_data_1 : in_data_0;
            out_id    <= in_ready_1;
            out_mod_1 <= in_ready_1 ? in_data_1[MAX_MOD-1:0] : in_data_0[MAX_MOD-1:0];
            r         <= '0;
            mod_sel   <= 2'd0;
            digit     <= 2'd3;
            state     <= RUN;
          end
        end
        RUN: begin
          if (digit == 2'd0) begin
            case (mod_sel)
              2'd0:    out_mod_2 <= red;
              2'd1:    out_mod_3 <= red;
              default: out_mod_4 <= red;
            endcase
            r       <= '0;
            digit   <= 2'd3;
            mod_sel <= mod_sel + 2'd1;
            if (mod_sel == 2'd2) begin
              state <= DONE;
            end
          end else begin
            r     <= red;
            digit <= digit - 2'd1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bin2rns_sched.sv
// Self-checking bench for bin2rns_sched: residues come from plain % arithmetic, grants from a pointer model.
// The arbitration expectations follow BIN2RNS_SCHED_RR_EN, the same macro as the design.
module tb_bin2rns_sched;

  logic        clk        = 1'b0;
  logic        reset      = 1'b0;
  logic        in_valid_0 = 1'b0;
  logic        in_valid_1 = 1'b0;
  logic [15:0] in_data_0  = '0;
  logic [15:0] in_data_1  = '0;
  logic        out_ready  = 1'b0;
  logic        in_ready_0, in_ready_1, out_valid, out_id, busy;
  logic [4:0]  out_mod_1, out_mod_2, out_mod_3, out_mod_4;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit ptr    = 1'b0;
  int mods[4] = '{32, 31, 21, 5};

  bin2rns_sched #(.DYN_SIZE(16), .MAX_MOD(5)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid_0 (in_valid_0),
    .in_valid_1 (in_valid_1),
    .in_data_0  (in_data_0),
    .in_data_1  (in_data_1),
    .in_ready_0 (in_ready_0),
    .in_ready_1 (in_ready_1),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_id     (out_id),
    .out_mod_1  (out_mod_1),
    .out_mod_2  (out_mod_2),
    .out_mod_3  (out_mod_3),
    .out_mod_4  (out_mod_4),
    .busy       (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #800000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic void ref_res(input logic [15:0] v, output logic [4:0] e[4]);
    for (int i = 0; i < 4; i++) e[i] = 5'(int'(v) % mods[i]);
  endfunction

  function automatic void get_res(output logic [4:0] g[4]);
    g[0] = out_mod_1; g[1] = out_mod_2; g[2] = out_mod_3; g[3] = out_mod_4;
  endfunction

  // Expected winner for a request pattern; priority moves to the other requester after each grant.
  function automatic bit model_grant(input bit v0, input bit v1);
    bit k;
    if (v0 && v1) begin
`ifdef BIN2RNS_SCHED_RR_EN
      k = ptr;
`else
      k = 1'b0;
`endif
    end else begin
      k = !v0;
    end
    ptr = !k;
    return k;
  endfunction

  // Presents requests until one is granted, then waits for out_valid. lat counts clock edges
  // from the start of the grant cycle up to the edge after which out_valid is seen.
  task automatic run_op(input bit v0, input bit v1, input logic [15:0] d0, input logic [15:0] d1,
                        input bit rdy, output bit gid, output int lat, output bit tmo);
    int n = 0;
    tmo = 1'b0; gid = 1'b0; lat = 0;
    @(negedge clk);
    in_valid_0 = v0; in_valid_1 = v1; in_data_0 = d0; in_data_1 = d1; out_ready = rdy;
    #1;
    while (!in_ready_0 && !in_ready_1 && n < 40) begin
      @(negedge clk); #1; n++;
    end
    if (n >= 40) begin
      tmo = 1'b1; in_valid_0 = 1'b0; in_valid_1 = 1'b0;
      return;
    end
    gid = in_ready_1;
    @(posedge clk); lat = 1;
    @(negedge clk); in_valid_0 = 1'b0; in_valid_1 = 1'b0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); lat++; @(negedge clk);
    end
    if (!out_valid) tmo = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0; in_valid_0 = 1'b1; in_valid_1 = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++; if ({in_ready_0, in_ready_1} !== 2'b00) begin errors++; $display("FAIL reset_ready got %b exp 00", {in_ready_0, in_ready_1}); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (out_id !== 1'b0) begin errors++; $display("FAIL reset_out_id got %b exp 0", out_id); end
    checks++; if ({out_mod_1, out_mod_2, out_mod_3, out_mod_4} !== 20'h0) begin errors++; $display("FAIL reset_residues got %h exp 0", {out_mod_1, out_mod_2, out_mod_3, out_mod_4}); end
    in_valid_0 = 1'b0; in_valid_1 = 1'b0;
    reset = 1'b1;
    ptr = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL post_reset_busy got %b exp 0", busy); end
  endtask

  task automatic test_single();
    logic [15:0] vals[4] = '{16'hFFFF, 16'd1000, 16'd12346, 16'd0};
    bit          ks[4]   = '{1'b0, 1'b1, 1'b1, 1'b1};
    logic [4:0]  tab[4][4] = '{'{5'd31, 5'd1, 5'd15, 5'd0}, '{5'd8, 5'd8, 5'd13, 5'd0},
                               '{5'd26, 5'd8, 5'd19, 5'd1}, '{5'd0, 5'd0, 5'd0, 5'd0}};
    logic [4:0]  g[4];
    bit gid, tmo, k;
    int lat;
    for (int t = 0; t < 4; t++) begin
      run_op(!ks[t], ks[t], vals[t], vals[t], 1'b1, gid, lat, tmo);
      k = model_grant(!ks[t], ks[t]);
      checks++;
      if (tmo) begin errors++; $display("FAIL single_timeout N=%0d", vals[t]); continue; end
      checks++; if (lat != 13) begin errors++; $display("FAIL single_latency N=%0d got %0d exp 13", vals[t], lat); end
      checks++; if (out_id !== k) begin errors++; $display("FAIL single_id N=%0d got %b exp %b", vals[t], out_id, k); end
      get_res(g);
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (g[i] !== tab[t][i]) begin errors++; $display("FAIL single_mod%0d N=%0d got %0d exp %0d", i + 1, vals[t], g[i], tab[t][i]); end
      end
    end
  endtask

  task automatic test_arbitration();
    logic [15:0] d[2] = '{16'hFFFF, 16'd1000};
    logic [4:0]  g[4], e[4];
    int got = 0, last = 0, n = 0;
    bit k;
    @(negedge clk);
    out_ready = 1'b1; in_data_0 = d[0]; in_data_1 = d[1]; in_valid_0 = 1'b1; in_valid_1 = 1'b1;
    while (got < 4 && n < 100) begin
      @(negedge clk); n++;
      if (out_valid) begin
        k = model_grant(1'b1, 1'b1);
        checks++; if (out_id !== k) begin errors++; $display("FAIL arb_id result %0d got %b exp %b", got, out_id, k); end
        get_res(g); ref_res(d[k], e);
        for (int i = 0; i < 4; i++) begin
          checks++;
          if (g[i] !== e[i]) begin errors++; $display("FAIL arb_mod%0d result %0d got %0d exp %0d", i + 1, got, g[i], e[i]); end
        end
        if (got > 0) begin
          checks++; if (cyc - last != 14) begin errors++; $display("FAIL arb_spacing result %0d got %0d exp 14", got, cyc - last); end
        end
        last = cyc; got++;
        if (got == 4) begin in_valid_0 = 1'b0; in_valid_1 = 1'b0; end
      end
    end
    in_valid_0 = 1'b0; in_valid_1 = 1'b0;
    checks++; if (got != 4) begin errors++; $display("FAIL arb_count got %0d exp 4", got); end
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL arb_idle_busy got %b exp 0", busy); end
  endtask

  task automatic test_backpressure();
    logic [15:0] d;
    logic [4:0]  g[4], e[4];
    logic [19:0] hold;
    logic        hid;
    bit gid, tmo, k;
    int lat, nres = 0;
    d = 16'($urandom);
    run_op(1'b1, 1'b0, d, 16'h0, 1'b0, gid, lat, tmo);
    k = model_grant(1'b1, 1'b0);
    checks++;
    if (tmo) begin errors++; $display("FAIL bp_timeout N=%0d", d); out_ready = 1'b1; return; end
    checks++; if (out_id !== k) begin errors++; $display("FAIL bp_id got %b exp %b", out_id, k); end
    get_res(g); ref_res(d, e);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (g[i] !== e[i]) begin errors++; $display("FAIL bp_mod%0d N=%0d got %0d exp %0d", i + 1, d, g[i], e[i]); end
    end
    hold = {e[0], e[1], e[2], e[3]}; hid = k;
    in_data_1 = 16'($urandom); in_valid_0 = 1'b1; in_valid_1 = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid cycle %0d got %b exp 1", c, out_valid); end
      checks++; if ({out_mod_1, out_mod_2, out_mod_3, out_mod_4, out_id} !== {hold, hid}) begin
        errors++; $display("FAIL bp_hold_outputs cycle %0d got %h exp %h", c, {out_mod_1, out_mod_2, out_mod_3, out_mod_4, out_id}, {hold, hid});
      end
      checks++; if ({in_ready_0, in_ready_1} !== 2'b00) begin errors++; $display("FAIL bp_hold_ready cycle %0d got %b exp 00", c, {in_ready_0, in_ready_1}); end
    end
    @(negedge clk);
    out_ready = 1'b1; in_valid_0 = 1'b0; in_valid_1 = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (out_valid) nres++;
    end
    checks++; if (nres != 0) begin errors++; $display("FAIL bp_extra_results got %0d exp 0", nres); end
  endtask

  task automatic test_reset_mid_run();
    logic [4:0] g[4];
    bit gid, tmo, k;
    int lat, n = 0, nres = 0;
    @(negedge clk);
    in_valid_0 = 1'b1; in_data_0 = 16'hFFFF; out_ready = 1'b1;
    #1;
    while (!in_ready_0 && n < 40) begin @(negedge clk); #1; n++; end
    checks++;
    if (n >= 40) begin errors++; $display("FAIL rst_grant_timeout"); in_valid_0 = 1'b0; return; end
    k = model_grant(1'b1, 1'b0);
    @(posedge clk);
    @(negedge clk); in_valid_0 = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_busy_before got %b exp 1", busy); end
    reset = 1'b0;
    #1;
    checks++; if ({out_valid, busy, out_id, in_ready_0, in_ready_1} !== 5'b0) begin
      errors++; $display("FAIL rst_mid_flags got %b exp 00000", {out_valid, busy, out_id, in_ready_0, in_ready_1});
    end
    checks++; if ({out_mod_1, out_mod_2, out_mod_3, out_mod_4} !== 20'h0) begin
      errors++; $display("FAIL rst_mid_residues got %h exp 0", {out_mod_1, out_mod_2, out_mod_3, out_mod_4});
    end
    ptr = 1'b0;
    repeat (2) @(negedge clk);
    #1 reset = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (out_valid || busy) nres++;
    end
    checks++; if (nres != 0) begin errors++; $display("FAIL rst_abandoned got %0d active cycles exp 0", nres); end
    run_op(1'b1, 1'b1, 16'd12346, 16'd1000, 1'b1, gid, lat, tmo);
    k = model_grant(1'b1, 1'b1);
    checks++;
    if (tmo) begin errors++; $display("FAIL rst_next_timeout"); return; end
    checks++; if (out_id !== k) begin errors++; $display("FAIL rst_next_id got %b exp %b", out_id, k); end
    checks++; if (lat != 13) begin errors++; $display("FAIL rst_next_latency got %0d exp 13", lat); end
    get_res(g);
    checks++; if ({g[0], g[1], g[2], g[3]} !== {5'd26, 5'd8, 5'd19, 5'd1}) begin
      errors++; $display("FAIL rst_next_residues got %0d/%0d/%0d/%0d exp 26/8/19/1", g[0], g[1], g[2], g[3]);
    end
  endtask

  task automatic test_random_sweep();
    logic [15:0] edge_vals[13] = '{16'd0, 16'd1, 16'd4, 16'd5, 16'd20, 16'd21, 16'd30, 16'd31,
                                   16'd32, 16'h7FFF, 16'h8000, 16'hFFFE, 16'hFFFF};
    logic [15:0] v;
    logic [4:0]  g[4], e[4];
    bit gid, tmo, k, kk;
    int lat;
    for (int t = 0; t < 263; t++) begin
      v  = (t < 13) ? edge_vals[t] : 16'($urandom);
      kk = 1'($urandom_range(1, 0));
      run_op(!kk, kk, v, v, 1'b1, gid, lat, tmo);
      k = model_grant(!kk, kk);
      checks++;
      if (tmo) begin errors++; $display("FAIL sweep_timeout N=%0d", v); continue; end
      checks++; if (out_id !== k) begin errors++; $display("FAIL sweep_id N=%0d got %b exp %b", v, out_id, k); end
      checks++; if (lat != 13) begin errors++; $display("FAIL sweep_latency N=%0d got %0d exp 13", v, lat); end
      get_res(g); ref_res(v, e);
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (g[i] !== e[i]) begin errors++; $display("FAIL sweep_mod%0d N=%0d got %0d exp %0d", i + 1, v, g[i], e[i]); end
        checks++;
        if (!(int'(g[i]) < mods[i])) begin errors++; $display("FAIL sweep_range%0d N=%0d got %0d limit %0d", i + 1, v, g[i], mods[i]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_arbitration();
    test_backpressure();
    test_reset_mid_run();
    test_random_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
